// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, constants and column priority encode for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} keypad_state_e;

  localparam logic [3:0] ROW_INIT   = 4'b1000;
  localparam int         KEY_CODE_W = 4;

  // col[3] is column index 0; scanning low bit to high lets the highest set bit win
  function automatic logic [1:0] col_to_idx(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) idx = 2'(3 - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// rtl/keypad_sync2.sv - two-flop synchronizer for the asynchronous column return lines
module keypad_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// rtl/keypad_scan_decoder.sv - 4x4 keypad row sweep, debounce and key encode
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            col,
  output logic [3:0]            row,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);

  if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("keypad_scan_decoder: parameter out of range");
  end

  logic [3:0]            col_s;
  keypad_state_e         state_q, state_d;
  logic [1:0]            row_idx_q, row_idx_d;
  logic [DIV_W-1:0]      dwell_q, dwell_d;
  logic [DEB_W-1:0]      deb_q, deb_d, deb_inc;
  logic [3:0]            cand_q, cand_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  valid_q, valid_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  keypad_sync2 #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (col_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      row_idx_q <= 2'd0;
      dwell_q   <= '0;
      deb_q     <= '0;
      cand_q    <= 4'd0;
      code_q    <= '0;
      valid_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    cand_d    = cand_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    deb_inc   = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d     = '0;
`endif
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_s != 4'b0) begin
            cand_d  = col_s;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        // The whole column vector must stay put, not just the winning bit
        if (col_s == cand_q) begin
          deb_d = deb_inc;
          if (deb_inc == DEB_MAX) begin
            valid_d = 1'b1;
            code_d  = {row_idx_q, col_to_idx(cand_q)};
            state_d = HOLD;
          end
        end else begin
          state_d   = SCAN;
          row_idx_d = row_idx_q + 2'd1;
          dwell_d   = '0;
        end
      end
      HOLD: begin
        if (col_s == 4'b0) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_q == REP_LAST) begin
          valid_d = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (col_s == 4'b0) begin
          deb_d = deb_inc;
          if (deb_inc == DEB_MAX) begin
            state_d   = SCAN;
            row_idx_d = row_idx_q + 2'd1;
            dwell_d   = '0;
          end
        end else begin
          state_d = HOLD;
        end
      end
    endcase
  end

  always_comb begin
    row       = ROW_INIT >> row_idx_q;
    key_held  = (state_q == HOLD) || (state_q == RELEASE);
    key_code  = code_q;
    key_valid = valid_q;
  end

endmodule
